// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage RV32IM pipeline: per-stage hold and
// flush controls for data/instruction waits, load-use, redirects and long M ops.
//
//   state  | meaning
//   RUN    | normal issue; hazards evaluated by priority each cycle
//   MULDIV | multi-cycle M op occupying EX; cnt_q counts remaining stall cycles
module pipeline_hazard_ctrl #(
   parameter int MUL_LATENCY = 2,
   parameter int DIV_LATENCY = 8
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        IF_BUSYWAIT,
   input  logic        DMEM_BUSYWAIT,
   input  logic [4:0]  ID_RS1,
   input  logic [4:0]  ID_RS2,
   input  logic        ID_USES_RS1,
   input  logic        ID_USES_RS2,
   input  logic [4:0]  EX_RD,
   input  logic        EX_MEM_READ,
   input  logic        EX_MULDIV,
   input  logic        EX_MULDIV_IS_DIV,
   input  logic        EX_BRANCH_TAKEN,
   output logic        PC_HOLD,
   output logic        IFID_HOLD,
   output logic        IDEX_HOLD,
   output logic        EXMEM_HOLD,
   output logic        MEMWB_HOLD,
   output logic        IFID_FLUSH,
   output logic        IDEX_FLUSH,
   output logic        EXMEM_FLUSH,
   output logic        MULDIV_BUSY,
   output logic [31:0] STALL_COUNT
);

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_MULDIV = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [7:0]  lat;
   logic        load_use;

   assign lat = EX_MULDIV_IS_DIV ? 8'(DIV_LATENCY) : 8'(MUL_LATENCY);

   assign load_use = EX_MEM_READ && (EX_RD != 5'd0) &&
                     ((ID_USES_RS1 && (ID_RS1 == EX_RD)) ||
                      (ID_USES_RS2 && (ID_RS2 == EX_RD)));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      PC_HOLD     = 1'b0;
      IFID_HOLD   = 1'b0;
      IDEX_HOLD   = 1'b0;
      EXMEM_HOLD  = 1'b0;
      MEMWB_HOLD  = 1'b0;
      IFID_FLUSH  = 1'b0;
      IDEX_FLUSH  = 1'b0;
      EXMEM_FLUSH = 1'b0;
      MULDIV_BUSY = 1'b0;

      // Controls are forced idle while reset is asserted, whatever the inputs.
      if (!RESET) begin
         state_d = ST_RUN;
         cnt_d   = 8'd0;
      end else if (DMEM_BUSYWAIT) begin
         PC_HOLD    = 1'b1;
         IFID_HOLD  = 1'b1;
         IDEX_HOLD  = 1'b1;
         EXMEM_HOLD = 1'b1;
         MEMWB_HOLD = 1'b1;
      end else if (state_q == ST_MULDIV) begin
         if (cnt_q != 8'd0) begin
            PC_HOLD     = 1'b1;
            IFID_HOLD   = 1'b1;
            IDEX_HOLD   = 1'b1;
            EXMEM_FLUSH = 1'b1;
            MULDIV_BUSY = 1'b1;
            cnt_d       = cnt_q - 8'd1;
         end else begin
            state_d = ST_RUN;
         end
      end else if (EX_MULDIV && (lat > 8'd1)) begin
         // First stall cycle is spent here in RUN, so MULDIV covers L-2 more.
         PC_HOLD     = 1'b1;
         IFID_HOLD   = 1'b1;
         IDEX_HOLD   = 1'b1;
         EXMEM_FLUSH = 1'b1;
         MULDIV_BUSY = 1'b1;
         state_d     = ST_MULDIV;
         cnt_d       = lat - 8'd2;
      end else if (EX_BRANCH_TAKEN) begin
         IFID_FLUSH = 1'b1;
         IDEX_FLUSH = 1'b1;
      end else if (load_use) begin
         PC_HOLD    = 1'b1;
         IFID_HOLD  = 1'b1;
         IDEX_FLUSH = 1'b1;
      end else if (IF_BUSYWAIT) begin
         PC_HOLD    = 1'b1;
         IFID_FLUSH = 1'b1;
      end

      stall_cnt_d = stall_cnt_q;
      if (PC_HOLD && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q     <= ST_RUN;
         cnt_q       <= 8'd0;
         stall_cnt_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign STALL_COUNT = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus random
// stimulus against an occupancy-based reference model.
module tb_pipeline_hazard_ctrl;

   localparam int MUL_LAT = 4;
   localparam int DIV_LAT = 8;

   // {PC_H, IFID_H, IDEX_H, EXMEM_H, MEMWB_H, IFID_F, IDEX_F, EXMEM_F, BUSY}
   localparam logic [8:0] C_NONE = 9'b000_00_000_0;
   localparam logic [8:0] C_MD   = 9'b111_00_001_1;
   localparam logic [8:0] C_ALLH = 9'b111_11_000_0;
   localparam logic [8:0] C_BR   = 9'b000_00_110_0;
   localparam logic [8:0] C_LU   = 9'b110_00_010_0;
   localparam logic [8:0] C_IF   = 9'b100_00_100_0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_bw = 1'b0, dmem = 1'b0;
   logic [4:0]  rs1 = '0, rs2 = '0, ex_rd = '0;
   logic        u1 = 1'b0, u2 = 1'b0, mem_rd = 1'b0;
   logic        ex_md = 1'b0, is_div = 1'b0, br = 1'b0;

   logic        pc_h, ifid_h, idex_h, exmem_h, memwb_h;
   logic        ifid_f, idex_f, exmem_f, busy;
   logic [31:0] stall_count;
   logic [8:0]  ctrl_obs;

   int          n_checks = 0;
   int          n_fail = 0;

   // Reference model: m_left = non-wait cycles the current M op still occupies EX.
   int          m_left = 0;
   logic [31:0] m_stall = '0;

   pipeline_hazard_ctrl #(.MUL_LATENCY(MUL_LAT), .DIV_LATENCY(DIV_LAT)) dut (
      .CLK(clk), .RESET(rst_n),
      .IF_BUSYWAIT(if_bw), .DMEM_BUSYWAIT(dmem),
      .ID_RS1(rs1), .ID_RS2(rs2), .ID_USES_RS1(u1), .ID_USES_RS2(u2),
      .EX_RD(ex_rd), .EX_MEM_READ(mem_rd),
      .EX_MULDIV(ex_md), .EX_MULDIV_IS_DIV(is_div), .EX_BRANCH_TAKEN(br),
      .PC_HOLD(pc_h), .IFID_HOLD(ifid_h), .IDEX_HOLD(idex_h),
      .EXMEM_HOLD(exmem_h), .MEMWB_HOLD(memwb_h),
      .IFID_FLUSH(ifid_f), .IDEX_FLUSH(idex_f), .EXMEM_FLUSH(exmem_f),
      .MULDIV_BUSY(busy), .STALL_COUNT(stall_count)
   );

   assign ctrl_obs = {pc_h, ifid_h, idex_h, exmem_h, memwb_h, ifid_f, idex_f, exmem_f, busy};

   always #5 clk = ~clk;

   function automatic int cur_lat();
      return is_div ? DIV_LAT : MUL_LAT;
   endfunction

   function automatic logic [8:0] exp_ctrl();
      logic lu;
      lu = mem_rd && (ex_rd != 5'd0) && ((u1 && rs1 == ex_rd) || (u2 && rs2 == ex_rd));
      if (!rst_n)                        return C_NONE;
      if (dmem)                          return C_ALLH;
      if (m_left > 1)                    return C_MD;
      if (m_left == 1)                   return C_NONE;
      if (ex_md && cur_lat() > 1)        return C_MD;
      if (br)                            return C_BR;
      if (lu)                            return C_LU;
      if (if_bw)                         return C_IF;
      return C_NONE;
   endfunction

   // Advance one clock (from just after a negedge to the next negedge) and update the model.
   task automatic tick();
      logic [8:0] e;
      int         lat;
      e   = exp_ctrl();
      lat = cur_lat();
      @(posedge clk);
      if (rst_n) begin
         if (e[8] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
         if (!dmem) begin
            if (m_left > 0) m_left = m_left - 1;
            else if (ex_md && lat > 1) m_left = lat - 1;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      if_bw = 0; dmem = 0; rs1 = 0; rs2 = 0; ex_rd = 0;
      u1 = 0; u2 = 0; mem_rd = 0; ex_md = 0; is_div = 0; br = 0;
   endtask

   task automatic test_reset();
      rst_n = 0; dmem = 1; mem_rd = 1; ex_rd = 5'd3; rs1 = 5'd3; u1 = 1; br = 1;
      #2;
      n_checks++;
      if (ctrl_obs !== C_NONE) begin n_fail++; $display("FAIL reset_ctrl: got %b want %b", ctrl_obs, C_NONE); end
      n_checks++;
      if (stall_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", stall_count); end
      #4;
      n_checks++;
      if (ctrl_obs !== C_NONE || stall_count !== 32'd0) begin
         n_fail++; $display("FAIL reset_held: ctrl %b cnt %0d want %b 0", ctrl_obs, stall_count, C_NONE);
      end
      @(negedge clk);
      idle_inputs();
      rst_n = 1;
      m_left = 0; m_stall = '0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_checks++;
         if (ctrl_obs !== C_NONE) begin n_fail++; $display("FAIL reset_idle[%0d]: got %b want %b", c, ctrl_obs, C_NONE); end
         tick();
      end
   endtask

   task automatic test_div();
      logic [31:0] base;
      base = m_stall;
      ex_md = 1; is_div = 1;
      for (int c = 0; c < 8; c++) begin
         #1;
         n_checks++;
         if (ctrl_obs !== ((c < 7) ? C_MD : C_NONE) || ctrl_obs !== exp_ctrl()) begin
            n_fail++; $display("FAIL div_stall[%0d]: got %b want %b", c, ctrl_obs, (c < 7) ? C_MD : C_NONE);
         end
         tick();
      end
      ex_md = 0; is_div = 0;
      #1;
      n_checks++;
      if (stall_count !== base + 32'd7) begin n_fail++; $display("FAIL div_count: got %0d want %0d", stall_count, base + 32'd7); end
      tick();
   endtask

   task automatic test_load_use();
      logic [8:0] want [5];
      want = '{C_LU, C_NONE, C_NONE, C_LU, C_NONE};
      for (int c = 0; c < 5; c++) begin
         idle_inputs();
         case (c)
            0: begin mem_rd = 1; ex_rd = 5'd5; rs2 = 5'd5; u2 = 1; rs1 = 5'd2; u1 = 1; end
            1: begin ex_rd = 5'd5; rs2 = 5'd5; u2 = 1; end
            2: begin mem_rd = 1; ex_rd = 5'd0; rs2 = 5'd0; u2 = 1; end
            3: begin mem_rd = 1; ex_rd = 5'd7; rs1 = 5'd7; u1 = 1; end
            default: begin mem_rd = 1; ex_rd = 5'd7; rs1 = 5'd7; u1 = 0; end
         endcase
         #1;
         n_checks++;
         if (ctrl_obs !== want[c]) begin n_fail++; $display("FAIL load_use[%0d]: got %b want %b", c, ctrl_obs, want[c]); end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_branch_priority();
      br = 1; if_bw = 1; mem_rd = 1; ex_rd = 5'd9; rs1 = 5'd9; u1 = 1;
      #1;
      n_checks++;
      if (ctrl_obs !== C_BR || pc_h !== 1'b0) begin n_fail++; $display("FAIL branch_prio: got %b want %b", ctrl_obs, C_BR); end
      tick();
      br = 0;
      #1;
      n_checks++;
      if (ctrl_obs !== C_LU) begin n_fail++; $display("FAIL lu_over_if: got %b want %b", ctrl_obs, C_LU); end
      tick();
      mem_rd = 0;
      #1;
      n_checks++;
      if (ctrl_obs !== C_IF) begin n_fail++; $display("FAIL if_wait: got %b want %b", ctrl_obs, C_IF); end
      tick();
      idle_inputs();
   endtask

   task automatic test_dmem_in_mul();
      logic [8:0]  want [7];
      logic [31:0] base;
      want = '{C_MD, C_ALLH, C_ALLH, C_ALLH, C_MD, C_MD, C_NONE};
      base = m_stall;
      ex_md = 1; is_div = 0;
      for (int c = 0; c < 7; c++) begin
         dmem = (c >= 1 && c <= 3);
         #1;
         n_checks++;
         if (ctrl_obs !== want[c] || ctrl_obs !== exp_ctrl()) begin
            n_fail++; $display("FAIL mul_dmem[%0d]: got %b want %b", c, ctrl_obs, want[c]);
         end
         tick();
      end
      idle_inputs();
      #1;
      n_checks++;
      if (stall_count !== base + 32'd6) begin n_fail++; $display("FAIL mul_dmem_count: got %0d want %0d", stall_count, base + 32'd6); end
      tick();
   endtask

   task automatic test_back_to_back();
      ex_md = 1; is_div = 0;
      for (int c = 0; c < 8; c++) begin
         #1;
         n_checks++;
         if (ctrl_obs !== (((c % 4) == 3) ? C_NONE : C_MD)) begin
            n_fail++; $display("FAIL back_to_back[%0d]: got %b want %b", c, ctrl_obs, ((c % 4) == 3) ? C_NONE : C_MD);
         end
         tick();
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_async_reset();
      ex_md = 1; is_div = 1;
      for (int c = 0; c < 3; c++) tick();
      #2;
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL pre_reset_busy: got %b want 1", busy); end
      rst_n = 0;
      m_left = 0; m_stall = '0;
      #1;
      n_checks++;
      if (ctrl_obs !== C_NONE || stall_count !== 32'd0) begin
         n_fail++; $display("FAIL async_reset: ctrl %b cnt %0d want %b 0", ctrl_obs, stall_count, C_NONE);
      end
      @(negedge clk);
      rst_n = 1;
      #1;
      n_checks++;
      if (ctrl_obs !== C_MD) begin n_fail++; $display("FAIL reset_rerun: got %b want %b", ctrl_obs, C_MD); end
      tick();
      ex_md = 0; is_div = 0;
      for (int c = 0; c < 8; c++) tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         dmem   = ($urandom_range(0, 7) == 0);
         if_bw  = ($urandom_range(0, 3) == 0);
         br     = ($urandom_range(0, 5) == 0);
         ex_md  = ($urandom_range(0, 4) == 0);
         is_div = $urandom_range(0, 1) == 1;
         mem_rd = ($urandom_range(0, 2) == 0);
         ex_rd  = 5'($urandom_range(0, 3));
         rs1    = 5'($urandom_range(0, 3));
         rs2    = 5'($urandom_range(0, 3));
         u1     = $urandom_range(0, 1) == 1;
         u2     = $urandom_range(0, 1) == 1;
         #1;
         n_checks++;
         if (ctrl_obs !== exp_ctrl() || stall_count !== m_stall ||
             (ifid_h && ifid_f) || (idex_h && idex_f) || (exmem_h && exmem_f)) begin
            n_fail++;
            $display("FAIL random[%0d]: ctrl %b cnt %0d want %b %0d", c, ctrl_obs, stall_count, exp_ctrl(), m_stall);
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_div();
      test_load_use();
      test_branch_priority();
      test_dmem_in_mul();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the five-stage RV32IM pipeline. Each cycle it produces per-stage HOLD and FLUSH controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves data-memory waits, instruction-fetch waits, load-use hazards, taken branches/jumps and multi-cycle M-extension operations in EX. It sits beside the pipeline registers. Each register's BUSYWAIT input is driven by the matching `*_HOLD`. Each `*_FLUSH` loads all-zero (a bubble) on the next CLK edge.

## Interface
- MUL_LATENCY, 2, total EX-stage cycles for MUL/MULH*; legal range 1..255
- DIV_LATENCY, 8, total EX-stage cycles for DIV/DIVU/REM/REMU; legal range 1..255
- CLK  in  1  pipeline clock; all state updates on rising edge
- RESET  in  1  reset, asynchronous, active-low
- IF_BUSYWAIT  in  1  instruction memory not ready
- DMEM_BUSYWAIT  in  1  data memory not ready
- ID_RS1, ID_RS2  in  5 each  source registers of the instruction in ID
- ID_USES_RS1, ID_USES_RS2  in  1 each  ID instruction reads that source
- EX_RD  in  5  destination register of the instruction in EX
- EX_MEM_READ  in  1  instruction in EX is a load
- EX_MULDIV  in  1  instruction in EX is an M-extension op
- EX_MULDIV_IS_DIV  in  1  that op is a div/rem (qualifies EX_MULDIV)
- EX_BRANCH_TAKEN  in  1  branch/jump in EX redirects PC
- PC_HOLD, IFID_HOLD, IDEX_HOLD, EXMEM_HOLD, MEMWB_HOLD  out  1 each  freeze that register
- IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH  out  1 each  load a bubble into that register
- MULDIV_BUSY  out  1  stall currently caused by a multi-cycle M op
- STALL_COUNT  out  32  number of cycles with PC_HOLD=1, saturating

## Operation
- FSM states: RUN, MULDIV. There is an 8-bit down-counter CNT.
- All HOLD/FLUSH/MULDIV_BUSY outputs are combinational (Mealy) from state and inputs. Exactly one priority case applies per cycle:
  1. DMEM_BUSYWAIT=1: all five HOLDs=1, no flush. FSM, CNT and STALL_COUNT keep their function: STALL_COUNT still counts, but FSM and CNT do not advance.
  2. MULDIV state, CNT≠0: PC_HOLD, IFID_HOLD, IDEX_HOLD=1, EXMEM_FLUSH=1, MULDIV_BUSY=1. CNT decrements.
  3. MULDIV state, CNT=0: no controls asserted. Next state is RUN.
  4. RUN, EX_MULDIV=1 and latency L>1 (L = DIV_LATENCY if EX_MULDIV_IS_DIV, else MUL_LATENCY): the same outputs as case 2. Next state is MULDIV, with CNT ← L−2.
  5. RUN, EX_BRANCH_TAKEN=1: IFID_FLUSH=1, IDEX_FLUSH=1. The PC is not held, so it loads the target.
  6. RUN, load-use: EX_MEM_READ=1, EX_RD≠0, and (ID_USES_RS1 with ID_RS1=EX_RD) or (ID_USES_RS2 with ID_RS2=EX_RD). Outputs: PC_HOLD=1, IFID_HOLD=1, IDEX_FLUSH=1.
  7. RUN, IF_BUSYWAIT=1: PC_HOLD=1, IFID_FLUSH=1. Downstream stages advance.
  8. Otherwise all controls are 0.
- Total stall cycles for one M op is L−1. With L=1 there is no stall and no state change.
- EX_BRANCH_TAKEN, load-use and IF_BUSYWAIT are ignored in MULDIV, because the EX instruction there is the M op.
- The FSM re-triggers only from RUN. A back-to-back M op therefore starts its own stall in the cycle after release.
- HOLD and FLUSH are never both 1 for the same register.
- STALL_COUNT increments on each CLK edge where PC_HOLD=1, and stops at 32'hFFFFFFFF.

## Timing
- RESET=0 (at any time, including mid-MULDIV or mid-DMEM wait):
  - State is RUN, CNT=0, STALL_COUNT=0, immediately.
  - While in reset, all HOLD/FLUSH/MULDIV_BUSY outputs=0.
  - The first edge after RESET rises evaluates in RUN.
- Latency: controls are valid in the same cycle as their inputs and act on the next CLK edge. There is no registered delay.
- Load-use inserts exactly one bubble. In the following cycle the load is in MEM, so the hazard clears and forwarding applies.
- DMEM_BUSYWAIT arriving during MULDIV freezes CNT. The remaining stall is extended by the wait duration.
- A DMEM_BUSYWAIT edge coincident with the MULDIV release cycle: the release is deferred until the wait drops.

## Test plan
- Reset: hold RESET=0 for 5 ns with DMEM_BUSYWAIT=1. Required: all outputs 0 and STALL_COUNT=0. After release with idle inputs, all controls stay 0.
- DIV stall: with DIV_LATENCY=8, pulse EX_MULDIV=1 and EX_MULDIV_IS_DIV=1 in RUN. Required: PC_HOLD/IFID_HOLD/IDEX_HOLD/EXMEM_FLUSH/MULDIV_BUSY=1 for exactly 7 cycles, 0 in the 8th, and STALL_COUNT=7.
- Load-use: EX_MEM_READ=1, EX_RD=5, ID_RS2=5, ID_USES_RS2=1. Required: PC_HOLD=IFID_HOLD=IDEX_FLUSH=1 for 1 cycle. Repeating with EX_RD=0 gives no stall.
- Branch vs fetch wait: EX_BRANCH_TAKEN=1 together with IF_BUSYWAIT=1 and a load-use match. Required: only IFID_FLUSH=IDEX_FLUSH=1, and PC_HOLD=0.
- Memory wait inside MUL: with MUL_LATENCY=4, assert DMEM_BUSYWAIT for 3 cycles during the 2nd stall cycle. Required: all HOLDs=1 for those 3 cycles, then 2 further MULDIV stall cycles, then release. Total PC_HOLD count=6.
- Async reset mid-MULDIV: RESET=0 between clock edges. Required: MULDIV_BUSY drops immediately, the state returns to RUN, and STALL_COUNT reads 0.
